// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester front end for one shared combinational ALU
//            (IDLE -> EXEC -> RESP). Optional macro ALU_ARB_FIXED_PRIO_EN
//            replaces round-robin with fixed priority to requester 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid0,
  input  logic         req_valid1,
  output logic         req_ready0,
  output logic         req_ready1,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  input  logic [2:0]   ALUOp0,
  input  logic [2:0]   ALUOp1,
  output logic         resp_valid0,
  output logic         resp_valid1,
  input  logic         resp_ready0,
  input  logic         resp_ready1,
  output logic [W-1:0] C_out,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [2:0]   alu_Op,
  input  logic [W-1:0] alu_C,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [W-1:0]   c_out_q, c_out_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic           grant_q, grant_d;
  logic           sel;
  logic           any_valid;
  logic           accept;
  logic           rdy0, rdy1;
  logic           resp_ack;

  assign any_valid = req_valid0 | req_valid1;
  assign resp_ack  = grant_q ? resp_ready1 : resp_ready0;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign sel = ~req_valid0;
`else
  // last_q holds the most recent grant; reset to 1 so requester 0 wins first.
  logic last_q;

  assign sel = (req_valid0 & req_valid1) ? ~last_q : req_valid1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= sel;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    c_out_d  = c_out_q;
    grant_d  = grant_q;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        rdy0 = req_valid0 & ~sel;
        rdy1 = req_valid1 & sel;
        if (any_valid) begin
          accept   = 1'b1;
          state_d  = EXEC;
          grant_d  = sel;
          alu_a_d  = sel ? A1 : A0;
          alu_b_d  = sel ? B1 : B0;
          alu_op_d = sel ? ALUOp1 : ALUOp0;
        end
      end
      EXEC: begin
        c_out_d = alu_C;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      c_out_q  <= '0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      c_out_q  <= c_out_d;
      grant_q  <= grant_d;
    end
  end

  // Ready is combinational from IDLE, so gate it to stay low while in reset.
  assign req_ready0  = rdy0 & rst_n;
  assign req_ready1  = rdy1 & rst_n;
  assign resp_valid0 = (state_q == RESP) & ~grant_q;
  assign resp_valid1 = (state_q == RESP) & grant_q;
  assign C_out       = c_out_q;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_Op      = alu_op_q;
  assign grant_id    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed + random bench for alu_arbiter against a transaction
//            level reference model; honours ALU_ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid0, req_valid1, req_ready0, req_ready1;
  logic [W-1:0] A0, B0, A1, B1;
  logic [2:0]   ALUOp0, ALUOp1;
  logic         resp_valid0, resp_valid1, resp_ready0, resp_ready1;
  logic [W-1:0] C_out, alu_A, alu_B, alu_C;
  logic [2:0]   alu_Op;
  logic         grant_id;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction, age counted in cycles.
  bit           m_busy;
  int           m_age;
  bit           m_gid;
  bit           m_last;
  logic [W-1:0] m_a, m_b, m_c;
  logic [2:0]   m_op;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return (a < b) ? W'(1) : W'(0);
      3'b110:  return ~a;
      default: return a << b[4:0];
    endcase
  endfunction

  assign alu_C = ref_alu(alu_A, alu_B, alu_Op);

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .ALUOp0(ALUOp0), .ALUOp1(ALUOp1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .C_out(C_out), .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op),
    .alu_C(alu_C), .grant_id(grant_id)
  );

  function automatic bit model_pick(bit v0, bit v1, bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return !last;
    return v1;
`endif
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_busy = 0; m_age = 0; m_gid = 0; m_last = 1;
    m_a = '0; m_b = '0; m_c = '0; m_op = '0;
  endtask

  task check_outputs();
    bit e_r0, e_r1, e_v0, e_v1, pick;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
    if (rst_n) begin
      if (!m_busy) begin
        pick = model_pick(req_valid0, req_valid1, m_last);
        e_r0 = req_valid0 && !pick;
        e_r1 = req_valid1 && pick;
      end else begin
        e_v0 = (m_age >= 1) && !m_gid;
        e_v1 = (m_age >= 1) && m_gid;
      end
    end
    chk("req_ready0",  W'(req_ready0),  W'(e_r0));
    chk("req_ready1",  W'(req_ready1),  W'(e_r1));
    chk("resp_valid0", W'(resp_valid0), W'(e_v0));
    chk("resp_valid1", W'(resp_valid1), W'(e_v1));
    chk("C_out",       C_out,           m_c);
    chk("alu_A",       alu_A,           m_a);
    chk("alu_B",       alu_B,           m_b);
    chk("alu_Op",      W'(alu_Op),      W'(m_op));
    chk("grant_id",    W'(grant_id),    W'(m_gid));
  endtask

  task model_update();
    bit pick;
    if (!m_busy) begin
      if (req_valid0 || req_valid1) begin
        pick   = model_pick(req_valid0, req_valid1, m_last);
        m_busy = 1; m_age = 0; m_gid = pick; m_last = pick;
        m_a    = pick ? A1 : A0;
        m_b    = pick ? B1 : B0;
        m_op   = pick ? ALUOp1 : ALUOp0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      m_c   = ref_alu(m_a, m_b, m_op);
    end else if (m_gid ? resp_ready1 : resp_ready0) begin
      m_busy = 0;
    end
  endtask

  task cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit gseq [4];
  int k;

  initial begin
    req_valid0 = 0; req_valid1 = 0; resp_ready0 = 0; resp_ready1 = 0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0; ALUOp0 = '0; ALUOp1 = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gseq = '{0, 0, 0, 0};
`else
    gseq = '{0, 1, 0, 1};
`endif
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single operation from requester 0
    req_valid0 = 1; A0 = 5; B0 = 3; ALUOp0 = 3'b001; resp_ready0 = 1;
    cycle();
    req_valid0 = 0;
    chk("single_exec_alu_A", alu_A, 5);
    chk("single_exec_alu_Op", W'(alu_Op), W'(3'b001));
    cycle();
    chk("single_resp_valid0", W'(resp_valid0), W'(1'b1));
    chk("single_C_out", C_out, 2);
    cycle();
    cycle();

    // Both requesters valid continuously for four operations
    do_reset();
    req_valid0 = 1; A0 = 1; B0 = 1; ALUOp0 = 3'b000;
    req_valid1 = 1; A1 = 6; B1 = 3; ALUOp1 = 3'b010;
    resp_ready0 = 1; resp_ready1 = 1;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      cycle();
      if (resp_valid0 || resp_valid1) begin
        chk("rr_grant", W'(grant_id), W'(gseq[k]));
        chk("rr_C_out", C_out, 2);
        chk("rr_resp_port", W'(resp_valid1), W'(gseq[k]));
        k++;
      end
    end
    chk("rr_count", W'(k), W'(4));
    req_valid0 = 0; req_valid1 = 0;
    for (int i = 0; i < 4; i++) cycle();

    // Backpressure on requester 1
    req_valid1 = 1; A1 = 9; B1 = 4; ALUOp1 = 3'b001; resp_ready1 = 0;
    cycle();
    req_valid1 = 0; req_valid0 = 1; A0 = 2; B0 = 2; ALUOp0 = 3'b011;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_C_out", C_out, 5);
      chk("bp_resp_valid1", W'(resp_valid1), W'(1'b1));
    end
    resp_ready1 = 1;
    cycle();
    req_valid0 = 0; resp_ready0 = 1;
    for (int i = 0; i < 4; i++) cycle();

    // Reset while in EXEC, with requester 1 still pending afterwards
    req_valid1 = 1; A1 = 7; B1 = 2; ALUOp1 = 3'b000;
    cycle();
    do_reset();
    cycle();
    chk("post_reset_grant", W'(grant_id), W'(1'b1));
    req_valid1 = 0;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic, including the 110/111 opcodes and occasional resets
    for (int i = 0; i < 400; i++) begin
      req_valid0  = ($urandom_range(0, 3) != 0);
      req_valid1  = ($urandom_range(0, 2) != 0);
      resp_ready0 = ($urandom_range(0, 2) != 0);
      resp_ready1 = ($urandom_range(0, 2) != 0);
      A0 = $urandom; B0 = $urandom_range(0, 40);
      A1 = $urandom; B1 = $urandom_range(0, 40);
      ALUOp0 = 3'($urandom_range(0, 7));
      ALUOp1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: W, default 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have ports: req_valid0 / req_valid1  input  1 each  requester 0/1 has an operation pending.
REQ-005 SHALL have ports: req_ready0 / req_ready1  output  1 each  operation accepted this cycle when ANDed with req_valid.
REQ-006 SHALL have ports: A0, B0 / A1, B1  input  W each  requester operands.
REQ-007 SHALL have ports: ALUOp0 / ALUOp1  input  3 each  requester operation code.
REQ-008 SHALL have ports: resp_valid0 / resp_valid1  output  1 each  result available for requester 0/1.
REQ-009 SHALL have ports: resp_ready0 / resp_ready1  input  1 each  requester consumes its result.
REQ-010 SHALL have port: C_out  output  W  result shared by both responders, qualified by resp_validN.
REQ-011 SHALL have ports: alu_A, alu_B  output  W  operands driven to the shared combinational ALU.
REQ-012 SHALL have port: alu_Op  output  3  operation code driven to the shared ALU.
REQ-013 SHALL have port: alu_C  input  W  combinational result from the shared ALU.
REQ-014 SHALL have port: grant_id  output  1  index of the requester currently owning the ALU.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, req_readyN SHALL be high only for the selected requester; all req_ready SHALL be low in EXEC and RESP.
REQ-017 Selection SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-018 On handshake in IDLE: register A, B, ALUOp into alu_A/alu_B/alu_Op, set grant_id, go to EXEC next cycle.
REQ-019 In EXEC: capture alu_C into C_out at the clock edge and go to RESP; exactly one EXEC cycle.
REQ-020 In RESP: resp_valid[grant_id] SHALL be high, the other low; C_out and grant_id SHALL be held stable.
REQ-021 In RESP with resp_ready[grant_id] high: go to IDLE next cycle. No new request accepted in that same cycle.
REQ-022 Accept-to-resp_valid latency SHALL be 2 cycles. Minimum issue interval SHALL be 3 cycles.
REQ-023 alu_A/alu_B/alu_Op SHALL hold their last issued values outside EXEC.
REQ-024 Operand and opcode width SHALL pass unmodified. No arithmetic is performed in this block.
REQ-025 Opcodes 110/111 SHALL be forwarded unchanged; C_out SHALL be whatever alu_C returns.
REQ-026 Deassertion of req_validN in IDLE without a handshake SHALL be legal, with no state change.
REQ-027 resp_readyN SHALL be ignored while resp_validN is low.

Reset
REQ-028 Asserting rst_n low at any time, including mid-EXEC or mid-RESP, SHALL immediately force IDLE and discard any pending result.
REQ-029 During reset, all outputs SHALL be 0: req_ready*, resp_valid*, C_out, alu_A, alu_B, alu_Op, grant_id.
REQ-030 During reset, the round-robin pointer SHALL reset so that requester 0 wins the first simultaneous request.
REQ-031 After rst_n deasserts, the first handshake SHALL be possible at the first rising edge.

Configuration
REQ-032 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and the round-robin pointer SHALL be removed.
REQ-033 When ALU_ARB_FIXED_PRIO_EN is undefined, REQ-017 round-robin SHALL apply.

Verification
REQ-034 Single op: req_valid0, A0=5, B0=3, ALUOp0=001, resp_ready0=1 -> alu_A=5, alu_Op=001 in EXEC; resp_valid0=1, C_out=2 two cycles after accept.
REQ-035 Simultaneous: both valid continuously for 4 ops (op0 A=1,B=1,Op=000; op1 A=6,B=3,Op=010) -> grants 0,1,0,1; C_out 2,2,2,2; each resp_valid only on the granted port.
REQ-036 Backpressure: resp_ready1=0 for 5 cycles in RESP -> resp_valid1 and C_out held, req_ready0/1 stay low; release -> IDLE next cycle.
REQ-037 Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately; after release, a pending req_valid1 is granted on the first edge.
REQ-038 With ALU_ARB_FIXED_PRIO_EN: both valid for 3 ops -> grant_id=0 every time; requester 1 starved until req_valid0 drops.
